clock_div_ctrl: RTL
===================

Name: clock_div_ctrl

Overview:
- Run-time controller for the clock divider.
- Holds a programmable divide ratio N and sequences a divided clock `outclk` from `refclk`.
- Supports run, stop, single-step, and glitch-free ratio changes through a valid/ready config port.
- Sits between the CPU I/O-register logic and every slow-clock consumer, such as the display scan and the single-cycle computer clock.

Parameters:
- WIDTH, 32, width of the divide-ratio and phase counters.
- DEFAULT_N, 2, divide ratio loaded at reset; values below 2 are treated as 2.

Ports:
- refclk  in  1  reference clock; all logic is on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  new divide ratio offered.
- cfg_ready  out  1  controller can accept a ratio.
- cfg_div  in  WIDTH  requested N; effective N = max(cfg_div, 2).
- run  in  1  level; 1 = free-run, 0 = stop.
- step  in  1  pulse; in IDLE, produce exactly one outclk period.
- outclk  out  1  divided clock, registered.
- out_rise  out  1  one-refclk strobe coinciding with the outclk 0->1 edge.
- out_fall  out  1  one-refclk strobe coinciding with the outclk 1->0 edge.
- step_done  out  1  one-refclk strobe when a step period ends.
- cur_div  out  WIDTH  effective N currently in use.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (asynchronous, resetn=0):
  - state=IDLE, counter=0, outclk=0, out_rise/out_fall/step_done=0.
  - cur_div=max(DEFAULT_N, 2), pending empty, cfg_ready=1.
- Phase lengths: H = cur_div/2 (integer division), L = H. Period = 2H refclk cycles, so odd N rounds down (N=5 gives period 4).
- States: IDLE, RUN, STOPPING, STEP.
- IDLE:
  - outclk=0 and counter held at 0.
  - run=1 -> RUN. Otherwise step=1 -> STEP. run has priority over step.
- RUN/STEP phase counting:
  - Each edge: if counter >= phase_len-1, then counter<=0 and outclk toggles (with the matching strobe in the same cycle). Otherwise counter++.
  - phase_len is L while outclk=0 and H while outclk=1.
  - First rise occurs L edges after the state becomes RUN.
- RUN with run=0:
  - If outclk=0: go to IDLE next edge; the low phase is truncated and counter cleared. No short high pulse is ever produced.
  - If outclk=1: go to STOPPING.
- STOPPING:
  - Keeps counting; at the falling toggle goes to IDLE.
  - run=1 again before the fall returns to RUN with no phase disturbance.
- STEP:
  - Produces one low phase then one high phase.
  - At the falling toggle: goes to IDLE and pulses step_done.
  - run/step are ignored until the step completes.
- Config handshake:
  - Transfer occurs on cfg_valid & cfg_ready.
  - Outside IDLE: the value goes to a one-entry pending register and cfg_ready drops to 0 until it is applied.
  - Apply point: the falling toggle edge. cur_div updates on that edge and the following low phase uses the new L.
  - A value accepted on the same edge as a falling toggle waits for the next fall.
  - In IDLE: an accepted value updates cur_div on the next edge and cfg_ready stays 1. Any pending value is applied on entry to IDLE.
- Mid-operation reset: everything returns to the reset values immediately and any pending config is discarded.
- Widths: counter is WIDTH bits and never wraps, because the compare uses >=.

Optional Feature:
- Macro: CLKCTRL_DUTY_EN.
- Enabled:
  - Adds input cfg_high[WIDTH], captured together with cfg_div. It travels through the same pending/apply path and is exposed on output cur_high[WIDTH].
  - H = clamp(cfg_high, 1, N-1) and L = N-H, so the period is exactly N.
  - Reset cur_high = N/2.
- Disabled: ports absent; 50% duty as specified above.

Decomposition:
- Package clkctrl_pkg:
  - state enum (IDLE, RUN, STOPPING, STEP).
  - MIN_DIV=2.
  - Function for clamped N and phase lengths.
- One sub-module, clkctrl_phase_counter: counter, toggle, and rise/fall strobes for a given phase_len and enable. The controller FSM and config path live in the top.

Test Plan:
- Reset, then run=1 with N=4: first out_rise 2 edges after RUN entry; outclk toggles every 2 edges; cur_div=4, busy=1.
- RUN at N=4, offer cfg_div=10 mid high phase: cfg_ready drops; cur_div becomes 10 exactly at the next out_fall; next low phase lasts 5 cycles; cfg_ready returns to 1.
- RUN at N=8, drop run one cycle after out_rise: outclk stays high for the full 4 cycles, then IDLE. Repeat with run dropped in the low phase: IDLE next edge, no rise.
- IDLE, N=6, step pulse: exactly one period (3 low, 3 high), step_done on the falling edge, then IDLE. A second step during the period is ignored.
- cfg_div=0 and cfg_div=1 in IDLE: cur_div=2. cfg_div=5: period 4. Assert resetn=0 mid-RUN with a pending config: outclk=0 immediately, cur_div=DEFAULT_N.
- With CLKCTRL_DUTY_EN, N=5, cfg_high=1: outclk high 1 cycle, low 4 cycles, period 5. cfg_high=9 clamps to 4.

Source files
------------

// File: rtl/clkctrl_pkg.sv
// Shared types and helpers for the clock-divider controller.
// Optional duty-cycle control is enabled with the CLKCTRL_DUTY_EN macro (see clock_div_ctrl).
package clkctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_STOPPING,
        ST_STEP
    } state_e;

    localparam int unsigned MIN_DIV = 2;

    // Helpers operate on a wide word; callers zero-extend in and truncate out.
    localparam int unsigned FN_W = 64;
    typedef logic [FN_W-1:0] fn_word_t;
    localparam fn_word_t FN_ONE = 1;
    localparam fn_word_t FN_MIN = MIN_DIV;

    function automatic fn_word_t eff_div(input fn_word_t n);
        return (n < FN_MIN) ? FN_MIN : n;
    endfunction

    function automatic fn_word_t half_div(input fn_word_t n);
        return eff_div(n) >> 1;
    endfunction

    // High phase length for an explicit duty request, kept within [1, N-1].
    function automatic fn_word_t clamp_high(input fn_word_t n, input fn_word_t h);
        fn_word_t ne;
        ne = eff_div(n);
        if (h < FN_ONE)
            return FN_ONE;
        if (h > ne - FN_ONE)
            return ne - FN_ONE;
        return h;
    endfunction

endpackage

// File: rtl/clkctrl_phase_counter.sv
// Phase counter: alternates low/high phases of the requested lengths and emits
// registered rise/fall strobes aligned with the divided-clock edges.
module clkctrl_phase_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] low_len_i,
    input  logic [WIDTH-1:0] high_len_i,
    output logic             level_o,
    output logic             rise_o,
    output logic             fall_o,
    output logic             fall_tick_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d, phase_len;
    logic             level_q, level_d, rise_q, rise_d, fall_q, fall_d;
    logic             wrap;

    assign phase_len   = level_q ? high_len_i : low_len_i;
    assign wrap        = cnt_q >= (phase_len - WIDTH'(1));
    assign fall_tick_o = en_i & level_q & wrap;

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (clear_i) begin
            // Leaving to idle: a pending rise is swallowed, a real fall is still reported.
            cnt_d   = '0;
            level_d = 1'b0;
            fall_d  = fall_tick_o;
        end else if (en_i) begin
            if (wrap) begin
                cnt_d   = '0;
                level_d = ~level_q;
                rise_d  = ~level_q;
                fall_d  = level_q;
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/clock_div_ctrl.sv
// Run/stop/step controller for the divided clock with glitch-free ratio changes.
// Define CLKCTRL_DUTY_EN to add programmable high-phase length (cfg_high/cur_high).
module clock_div_ctrl
    import clkctrl_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEFAULT_N = 2
) (
    input  logic             refclk,
    input  logic             resetn,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_div,
`ifdef CLKCTRL_DUTY_EN
    input  logic [WIDTH-1:0] cfg_high,
    output logic [WIDTH-1:0] cur_high,
`endif
    input  logic             run,
    input  logic             step,
    output logic             outclk,
    output logic             out_rise,
    output logic             out_fall,
    output logic             step_done,
    output logic [WIDTH-1:0] cur_div,
    output logic             busy
);

    localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(eff_div(fn_word_t'(DEFAULT_N)));

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cur_div_q, cur_div_d, pend_div_q, pend_div_d, new_div;
    logic [WIDTH-1:0] high_len, low_len;
    logic             pend_vld_q, pend_vld_d, step_done_q, step_done_d;
    logic             accept, apply_pend, fall_tick, level;

    assign new_div = WIDTH'(eff_div(fn_word_t'(cfg_div)));

`ifdef CLKCTRL_DUTY_EN
    localparam logic [WIDTH-1:0] RST_HIGH = WIDTH'(half_div(fn_word_t'(DEFAULT_N)));
    logic [WIDTH-1:0] cur_high_q, cur_high_d, pend_high_q, pend_high_d, new_high;
    assign new_high = WIDTH'(clamp_high(fn_word_t'(cfg_div), fn_word_t'(cfg_high)));
    assign high_len = cur_high_q;
    assign low_len  = cur_div_q - cur_high_q;
    assign cur_high = cur_high_q;
`else
    assign high_len = cur_div_q >> 1;
    assign low_len  = high_len;
`endif

    clkctrl_phase_counter #(.WIDTH(WIDTH)) u_phase (
        .clk_i      (refclk),
        .rst_ni     (resetn),
        .en_i       (state_q != ST_IDLE),
        .clear_i    (state_d == ST_IDLE),
        .low_len_i  (low_len),
        .high_len_i (high_len),
        .level_o    (level),
        .rise_o     (out_rise),
        .fall_o     (out_fall),
        .fall_tick_o(fall_tick)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     if (run) state_d = ST_RUN;
                         else if (step) state_d = ST_STEP;
            // Stopping in the low phase truncates it; in the high phase the pulse completes.
            ST_RUN:      if (!run) state_d = (!level || fall_tick) ? ST_IDLE : ST_STOPPING;
            ST_STOPPING: if (run) state_d = ST_RUN;
                         else if (fall_tick) state_d = ST_IDLE;
            ST_STEP:     if (fall_tick) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    assign cfg_ready   = ~pend_vld_q;
    assign accept      = cfg_valid & cfg_ready;
    assign apply_pend  = pend_vld_q & (fall_tick | state_q == ST_IDLE | state_d == ST_IDLE);
    assign step_done_d = (state_q == ST_STEP) & fall_tick;

    always_comb begin
        cur_div_d  = cur_div_q;
        pend_div_d = pend_div_q;
        pend_vld_d = pend_vld_q;
`ifdef CLKCTRL_DUTY_EN
        cur_high_d  = cur_high_q;
        pend_high_d = pend_high_q;
`endif
        if (apply_pend) begin
            cur_div_d  = pend_div_q;
            pend_vld_d = 1'b0;
`ifdef CLKCTRL_DUTY_EN
            cur_high_d = pend_high_q;
`endif
        end
        // A ratio accepted while running is held until the next falling edge.
        if (accept) begin
            if (state_q == ST_IDLE) begin
                cur_div_d = new_div;
`ifdef CLKCTRL_DUTY_EN
                cur_high_d = new_high;
`endif
            end else begin
                pend_vld_d = 1'b1;
                pend_div_d = new_div;
`ifdef CLKCTRL_DUTY_EN
                pend_high_d = new_high;
`endif
            end
        end
    end

    always_ff @(posedge refclk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            cur_div_q   <= RST_DIV;
            pend_div_q  <= RST_DIV;
            pend_vld_q  <= 1'b0;
            step_done_q <= 1'b0;
`ifdef CLKCTRL_DUTY_EN
            cur_high_q  <= RST_HIGH;
            pend_high_q <= RST_HIGH;
`endif
        end else begin
            state_q     <= state_d;
            cur_div_q   <= cur_div_d;
            pend_div_q  <= pend_div_d;
            pend_vld_q  <= pend_vld_d;
            step_done_q <= step_done_d;
`ifdef CLKCTRL_DUTY_EN
            cur_high_q  <= cur_high_d;
            pend_high_q <= pend_high_d;
`endif
        end
    end

    assign outclk    = level;
    assign step_done = step_done_q;
    assign cur_div   = cur_div_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
